imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder_if.sv | 22 ++
 rtl/imm_encoder.sv | 142 ++++++++++++++
 tb/tb_imm_encoder.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_if.sv
// Request/result bundle for imm_encoder: the immediate request channel in, the encoded field channel out.
// master drives requests and consumes results; slave is the encoder side.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  logic [2:0]  in_src;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_field;
  logic        out_err;

  modport master (
    output in_valid, in_imm, in_src, out_ready,
    input  in_ready, out_valid, out_field, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_src, out_ready,
    output in_ready, out_valid, out_field, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs a decoder-convention immediate into instruction bits [31:7] for I/U/S/B/J formats.
// Latency 2 cycles (input register, output register), one result per cycle when out_ready=1.
// Backpressure: stages advance only into an empty or draining successor; a full pipe drops in_ready.
// Range checking of encodability is compiled in only when IMM_RANGE_CHECK_EN is defined.
module imm_encoder (
  input  logic             clk,
  input  logic             rst_n,
  imm_encoder_if.slave     bus,
  input  logic             err_clr,
  output logic [7:0]       err_count
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_U = 3'b001;
  localparam logic [2:0] SRC_S = 3'b010;
  localparam logic [2:0] SRC_B = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;

  logic        s1_vld_q, s1_vld_d;
  logic [31:0] s1_imm_q, s1_imm_d;
  logic [2:0]  s1_src_q, s1_src_d;
  logic        out_vld_q, out_vld_d;
  logic [24:0] out_field_q, out_field_d;
  logic        out_err_q, out_err_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        s2_adv;
  logic        s1_adv;
  logic        in_acc;
  logic        out_xfer;
  logic [31:0] enc_instr;
  logic        enc_unsup;
  logic        enc_err;
  logic [24:0] enc_field;

  // Handshake: the output register frees up whenever it is empty or being consumed.
  always_comb begin
    s2_adv   = !out_vld_q || bus.out_ready;
    s1_adv   = s1_vld_q && s2_adv;
    in_acc   = bus.in_valid && (!s1_vld_q || s2_adv);
    out_xfer = out_vld_q && bus.out_ready;
  end

  // Bit scatter from the immediate into instruction positions.
  always_comb begin
    enc_instr = '0;
    enc_unsup = 1'b0;
    case (s1_src_q)
      SRC_I: enc_instr[31:20] = s1_imm_q[11:0];
      SRC_U: enc_instr[31:12] = s1_imm_q[31:12];
      SRC_S: begin
        enc_instr[31:25] = s1_imm_q[11:5];
        enc_instr[11:7]  = s1_imm_q[4:0];
      end
      SRC_B: begin
        enc_instr[31]    = s1_imm_q[11];
        enc_instr[7]     = s1_imm_q[10];
        enc_instr[30:25] = s1_imm_q[9:4];
        enc_instr[11:8]  = s1_imm_q[3:0];
      end
      SRC_J: begin
        enc_instr[31]    = s1_imm_q[19];
        enc_instr[19:12] = s1_imm_q[18:11];
        enc_instr[20]    = s1_imm_q[10];
        enc_instr[30:21] = s1_imm_q[9:0];
      end
      default: enc_unsup = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic sext12_ok;
  logic sext20_ok;
  logic low_zero;
  logic range_ok;

  // A value fits when every bit above the field's sign bit replicates it.
  always_comb begin
    sext12_ok = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
    sext20_ok = (&s1_imm_q[31:19]) || !(|s1_imm_q[31:19]);
    low_zero  = !(|s1_imm_q[11:0]);
    case (s1_src_q)
      SRC_I, SRC_S, SRC_B: range_ok = sext12_ok;
      SRC_J:               range_ok = sext20_ok;
      SRC_U:               range_ok = low_zero;
      default:             range_ok = 1'b1;
    endcase
    enc_err = enc_unsup || !range_ok;
  end
`else
  always_comb begin
    enc_err = enc_unsup;
  end
`endif

  always_comb begin
    enc_field = enc_err ? 25'd0 : enc_instr[31:7];
  end

  always_comb begin
    s1_vld_d    = in_acc || (s1_vld_q && !s2_adv);
    s1_imm_d    = in_acc ? bus.in_imm : s1_imm_q;
    s1_src_d    = in_acc ? bus.in_src : s1_src_q;
    out_vld_d   = s2_adv ? s1_vld_q : out_vld_q;
    out_field_d = s1_adv ? enc_field : out_field_q;
    out_err_d   = s1_adv ? enc_err : out_err_q;
    err_count_d = err_count_q;
    // Clear takes priority over a same-cycle errored delivery.
    if (err_clr) begin
      err_count_d = 8'd0;
    end else if (out_xfer && out_err_q && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_imm_q    <= '0;
      s1_src_q    <= '0;
      out_vld_q   <= 1'b0;
      out_field_q <= '0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_imm_q    <= s1_imm_d;
      s1_src_q    <= s1_src_d;
      out_vld_q   <= out_vld_d;
      out_field_q <= out_field_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = !s1_vld_q || s2_adv;
  assign bus.out_valid = out_vld_q;
  assign bus.out_field = out_field_q;
  assign bus.out_err   = out_err_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomised bench for imm_encoder: queue-based reference model plus directed literal cases.
// Expectations follow IMM_RANGE_CHECK_EN the same way the design does.
module tb_imm_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] err_count;

  imm_encoder_if bus();

  imm_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int ec = 0;
  always @(posedge clk) ec++;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  src;
    logic [31:0] ins;
    logic        err;
    logic        ok;
    int          pres;
  } exp_t;

  exp_t        q[$];
  logic [31:0] del_hist[$];
  int          tests = 0;
  int          fails = 0;
  int          m_cnt = 0;
  int          dels = 0;
  logic        last_err;
  int          last_lat;
  bit          saw_block;
  bit          acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic encodable(input logic [31:0] imm, input logic [2:0] src);
    int s;
    s = signed'(imm);
    case (src)
      3'd0, 3'd2, 3'd3: return (s >= -2048) && (s < 2048);
      3'd4:             return (s >= -(1 << 19)) && (s < (1 << 19));
      3'd1:             return (imm % 4096) == 0;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] imm, input logic [2:0] src);
    exp_t e;
    e.imm = imm;
    e.src = src;
    e.ok  = encodable(imm, src);
    e.pres = 0;
    case (src)
      3'd0: e.ins = {imm[11:0], 20'b0};
      3'd1: e.ins = {imm[31:12], 12'b0};
      3'd2: e.ins = {imm[11:5], 13'b0, imm[4:0], 7'b0};
      3'd3: e.ins = {imm[11], imm[9:4], 13'b0, imm[3:0], imm[10], 7'b0};
      3'd4: e.ins = {imm[19], imm[9:0], imm[10], imm[18:11], 12'b0};
      default: e.ins = 32'd0;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    e.err = !e.ok;
`else
    e.err = (src > 3'd4);
`endif
    if (e.err) e.ins = 32'd0;
    return e;
  endfunction

  function automatic logic [31:0] decode(input logic [31:0] w, input logic [2:0] src);
    case (src)
      3'd0: return {{20{w[31]}}, w[31:20]};
      3'd1: return {w[31:12], 12'b0};
      3'd2: return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3: return {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
      3'd4: return {{12{w[31]}}, w[31], w[19:12], w[20], w[30:21]};
      default: return 32'd0;
    endcase
  endfunction

  // One clock: drive at the falling edge, check settled outputs, then advance the model
  // for the transfers that the next rising edge will perform.
  task automatic cycle(input bit v, input logic [31:0] imm, input logic [2:0] src,
                       input bit ordy, input bit clr, output bit accepted);
    logic [31:0] word;
    bit          exp_v;
    exp_t        e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_imm    = imm;
    bus.in_src    = src;
    bus.out_ready = ordy;
    err_clr       = clr;
    #1;
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, (q.size() < 2) || ordy});
    exp_v = (q.size() > 0) && ((ec - q[0].pres) >= 2);
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_v});
    chk("err_count", {24'b0, err_count}, m_cnt);
    word = {bus.out_field, 7'b0};
    if (bus.out_valid && q.size() > 0) begin
      chk("out_field", word, q[0].ins);
      chk("out_err", {31'b0, bus.out_err}, {31'b0, q[0].err});
      if (!q[0].err && q[0].ok)
        chk("roundtrip", decode(word, q[0].src), q[0].imm);
    end
    if (!bus.in_ready) saw_block = 1'b1;
    accepted = v && bus.in_ready;
    if (bus.out_valid && ordy) begin
      dels++;
      del_hist.push_back(word);
      last_err = bus.out_err;
      if (q.size() > 0) begin
        last_lat = ec - q[0].pres;
        if (clr) m_cnt = 0;
        else if (q[0].err && m_cnt < 255) m_cnt++;
        void'(q.pop_front());
      end
    end else if (clr) begin
      m_cnt = 0;
    end
    if (accepted) begin
      e = model(imm, src);
      e.pres = ec;
      q.push_back(e);
    end
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, a);
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 8191)) - 32'd4096;
      1: return $urandom;
      2: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
      default: return $urandom & 32'hFFFF_F000;
    endcase
  endfunction

  initial begin
    int dels_before;
    int sent;
    int guard;
    logic [31:0] seq_imm [3];

    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_src    = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_field", {7'b0, bus.out_field}, 32'd0);
    chk("rst_out_err", {31'b0, bus.out_err}, 32'd0);
    chk("rst_err_count", {24'b0, err_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", {31'b0, bus.in_ready}, 32'd1);

    // I-type negative extreme.
    cycle(1'b1, 32'hFFFF_F800, 3'd0, 1'b1, 1'b0, acc);
    idle(3);
    chk("i_neg_field", del_hist[del_hist.size()-1], 32'h8000_0000);
    chk("i_neg_err", {31'b0, last_err}, 32'd0);
    chk("i_neg_latency", last_lat, 32'd2);

    // I-type one past the positive limit.
    del_hist.delete();
    cycle(1'b1, 32'h0000_0800, 3'd0, 1'b1, 1'b0, acc);
    idle(3);
    post_edge();
`ifdef IMM_RANGE_CHECK_EN
    chk("i_over_field", del_hist[0], 32'h0000_0000);
    chk("i_over_err", {31'b0, last_err}, 32'd1);
    chk("i_over_count", {24'b0, err_count}, 32'd1);
`else
    chk("i_over_field", del_hist[0], 32'h8000_0000);
    chk("i_over_err", {31'b0, last_err}, 32'd0);
    chk("i_over_count", {24'b0, err_count}, 32'd0);
`endif

    // B and J back to back.
    del_hist.delete();
    cycle(1'b1, 32'hFFFF_FFFE, 3'd3, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h0000_0001, 3'd4, 1'b1, 1'b0, acc);
    idle(4);
    chk("bj_count", del_hist.size(), 32'd2);
    if (del_hist.size() >= 2) begin
      chk("b_field", del_hist[0], 32'hFE00_0E80);
      chk("j_field", del_hist[1], 32'h0020_0000);
    end

    // Three requests into a stalled consumer.
    del_hist.delete();
    saw_block = 1'b0;
    seq_imm[0] = 32'd5;
    seq_imm[1] = 32'hFFFF_FFF9;
    seq_imm[2] = 32'd100;
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(sent < 3, (sent < 3) ? seq_imm[sent] : 32'd0, 3'd0, 1'b0, 1'b0, acc);
      if (acc) sent++;
    end
    guard = 0;
    while ((sent < 3 || q.size() > 0) && guard < 20) begin
      cycle(sent < 3, (sent < 3) ? seq_imm[sent] : 32'd0, 3'd0, 1'b1, 1'b0, acc);
      if (acc) sent++;
      guard++;
    end
    chk("stall_no_timeout", {31'b0, guard < 20}, 32'd1);
    chk("stall_saw_block", {31'b0, saw_block}, 32'd1);
    chk("stall_count", del_hist.size(), 32'd3);
    if (del_hist.size() >= 3) begin
      chk("stall_0", del_hist[0], 32'h0050_0000);
      chk("stall_1", del_hist[1], 32'hFF90_0000);
      chk("stall_2", del_hist[2], 32'h0640_0000);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_imm(), 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, acc);
    end
    idle(4);

    // Saturation and clear-wins.
    for (int i = 0; i < 310; i++) cycle(1'b1, $urandom, 3'd5, 1'b1, 1'b0, acc);
    idle(3);
    post_edge();
    chk("sat_count", {24'b0, err_count}, 32'd255);
    cycle(1'b1, 32'd0, 3'd6, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'd0, 3'd7, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b1, acc);
    post_edge();
    chk("clr_wins", {24'b0, err_count}, 32'd0);
    idle(3);

    // Asynchronous reset with a full pipe.
    for (int i = 0; i < 4; i++) cycle(1'b1, rand_imm(), 3'($urandom_range(0, 4)), 1'b0, 1'b0, acc);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid_rst_out_field", {7'b0, bus.out_field}, 32'd0);
    chk("mid_rst_err_count", {24'b0, err_count}, 32'd0);
    q.delete();
    m_cnt = 0;
    dels_before = dels;
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    chk("no_delivery_after_reset", dels, dels_before);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
